// File: rtl/cpu_state_dumper.sv
// rtl/cpu_state_dumper.sv - streams a cycle-count header, the register file and low data memory as 32-bit beats
//
// Purpose:
//    On dump_req_i (sampled only while idle) the free-running cycle counter is
//    snapshotted into a header beat. It is followed by NUM_REGS register beats
//    and MEM_WORDS data-memory beats, all over a valid/ready stream.
//
// Ports:
//    clk_i, rst_i           clock, synchronous active-high reset
//    dump_req_i             start a dump (ignored while busy)
//    busy_o, done_o         dump in progress / one-cycle completion pulse
//    reg_addr_o, reg_data_i register-file read port (combinational data)
//    mem_rd_o, mem_addr_o   data-memory read strobe and byte address
//    mem_data_i             memory data, valid the cycle after mem_rd_o
//    out_valid_o/out_ready_i/out_data_o/out_tag_o/out_idx_o/out_last_o  beat stream
module cpu_state_dumper #(
   parameter int NUM_REGS  = 32,
   parameter int MEM_WORDS = 8,
   parameter int CNT_W     = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        dump_req_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [4:0]  reg_addr_o,
   input  logic [31:0] reg_data_i,
   output logic        mem_rd_o,
   output logic [31:0] mem_addr_o,
   input  logic [31:0] mem_data_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_data_o,
   output logic [1:0]  out_tag_o,
   output logic [4:0]  out_idx_o,
   output logic        out_last_o
);

   localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);
   localparam logic [4:0] LAST_MEM = 5'(MEM_WORDS - 1);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_REG, S_MRD, S_MCAP} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [4:0]         r_reg_addr;
   logic               r_mem_rd;
   logic [31:0]        r_mem_addr;
   logic               r_valid;
   logic [31:0]        r_data;
   logic [1:0]         r_tag;
   logic [4:0]         r_idx;
   logic               r_last;
   // High only in the first MCAP cycle: memory data arrives that cycle and is
   // shown straight through while it is also latched into r_data, which keeps
   // memory beats at two cycles each.
   logic               r_mbyp;

   logic               w_xfer;
   logic [4:0]         w_next_k;

   assign w_xfer   = r_valid && out_ready_i;
   assign w_next_k = r_idx + 5'd1;

   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign reg_addr_o  = r_reg_addr;
   assign mem_rd_o    = r_mem_rd;
   assign mem_addr_o  = r_mem_addr;
   assign out_valid_o = r_valid;
   assign out_data_o  = r_mbyp ? mem_data_i : r_data;
   assign out_tag_o   = r_tag;
   assign out_idx_o   = r_idx;
   assign out_last_o  = r_last;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_reg_addr <= 5'd0;
         r_mem_rd   <= 1'b0;
         r_mem_addr <= 32'd0;
         r_valid    <= 1'b0;
         r_data     <= 32'd0;
         r_tag      <= 2'd0;
         r_idx      <= 5'd0;
         r_last     <= 1'b0;
         r_mbyp     <= 1'b0;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (dump_req_i) begin
                  r_data     <= 32'(r_cnt);
                  r_tag      <= 2'd0;
                  r_idx      <= 5'd0;
                  r_last     <= 1'b0;
                  r_valid    <= 1'b1;
                  r_busy     <= 1'b1;
                  r_reg_addr <= 5'd0;
                  r_state    <= S_HDR;
               end
            end
            // reg_addr_o always points one register ahead of the beat on
            // display, so the next register is loaded on the transfer edge.
            S_HDR: begin
               if (w_xfer) begin
                  r_data     <= reg_data_i;
                  r_tag      <= 2'd1;
                  r_idx      <= 5'd0;
                  r_reg_addr <= 5'd1;
                  r_state    <= S_REG;
               end
            end
            S_REG: begin
               if (w_xfer) begin
                  if (r_idx == LAST_REG) begin
                     r_valid    <= 1'b0;
                     r_reg_addr <= 5'd0;
                     r_idx      <= 5'd0;
                     r_mem_rd   <= 1'b1;
                     r_mem_addr <= 32'd0;
                     r_state    <= S_MRD;
                  end else begin
                     r_data     <= reg_data_i;
                     r_idx      <= w_next_k;
                     r_reg_addr <= r_reg_addr + 5'd1;
                  end
               end
            end
            S_MRD: begin
               r_mem_rd <= 1'b0;
               r_valid  <= 1'b1;
               r_tag    <= 2'd2;
               r_last   <= (r_idx == LAST_MEM);
               r_mbyp   <= 1'b1;
               r_state  <= S_MCAP;
            end
            S_MCAP: begin
               if (r_mbyp) begin
                  r_data <= mem_data_i;
                  r_mbyp <= 1'b0;
               end
               if (w_xfer) begin
                  r_valid <= 1'b0;
                  r_mbyp  <= 1'b0;
                  r_last  <= 1'b0;
                  if (r_last) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_idx      <= w_next_k;
                     r_mem_rd   <= 1'b1;
                     r_mem_addr <= {25'd0, w_next_k, 2'b00};
                     r_state    <= S_MRD;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_state_dumper.sv
// tb/tb_cpu_state_dumper.sv - randomized self-checking bench for cpu_state_dumper
module tb_cpu_state_dumper;

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  t;
      logic [4:0]  i;
      logic        l;
   } beat_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        dump_req_i = 1'b0;
   logic        out_ready_i = 1'b0;
   logic        busy_o, done_o, mem_rd_o, out_valid_o, out_last_o;
   logic [4:0]  reg_addr_o, out_idx_o;
   logic [31:0] reg_data_i, mem_data_i, mem_addr_o, out_data_o;
   logic [1:0]  out_tag_o;

   logic [31:0] regs [32];
   logic [7:0]  mem_b [32];

   int n_chk = 0;
   int n_pass = 0;

   // reference model state (written only by the monitor)
   logic [31:0] m_cnt = 32'd0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   int          m_memk = 0;
   int          m_mem_xfer = 0;
   bit          p_stall = 1'b0;
   beat_t       p_beat;
   beat_t       exp_q[$];
   beat_t       obs_q[$];
   int          n_done = 0;
   int          n_beats = 0;
   int          busy_cycles = 0;
   int          ovr_seen = 0;

   // counter override request (written only by the main process)
   int          ovr_seq = 0;
   logic [31:0] ovr_val = 32'd0;
   bit          rnd_ready = 1'b0;

   always #5 clk_i = ~clk_i;

   cpu_state_dumper dut (
      .clk_i(clk_i), .rst_i(rst_i), .dump_req_i(dump_req_i),
      .busy_o(busy_o), .done_o(done_o),
      .reg_addr_o(reg_addr_o), .reg_data_i(reg_data_i),
      .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_tag_o(out_tag_o),
      .out_idx_o(out_idx_o), .out_last_o(out_last_o)
   );

   function automatic logic [31:0] mword(input int k);
      return {mem_b[4*k+3], mem_b[4*k+2], mem_b[4*k+1], mem_b[4*k]};
   endfunction

   assign reg_data_i = regs[reg_addr_o];

   // synchronous memory: data only in the cycle after a strobe, noise otherwise
   always @(posedge clk_i)
      mem_data_i <= mem_rd_o ? mword(int'(mem_addr_o[4:2])) : $urandom();

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk_i) begin
      beat_t       cur;
      bit          was_busy;
      logic [31:0] ce;
      cur = {out_data_o, out_tag_o, out_idx_o, out_last_o};
      chk("busy", 32'(busy_o), 32'(m_busy));
      chk("done", 32'(done_o), 32'(m_done));
      if (!m_busy) chk("valid_idle", 32'(out_valid_o), 32'd0);
      else if (out_valid_o) begin
         if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
         else begin
            chk("beat_data", cur.d, exp_q[0].d);
            chk("beat_tag", 32'(cur.t), 32'(exp_q[0].t));
            chk("beat_idx", 32'(cur.i), 32'(exp_q[0].i));
            chk("beat_last", 32'(cur.l), 32'(exp_q[0].l));
         end
      end
      if (p_stall) begin
         chk("stall_valid", 32'(out_valid_o), 32'd1);
         chk("stall_data", cur.d, p_beat.d);
         chk("stall_meta", 32'(cur[7:0]), 32'(p_beat[7:0]));
      end
      if (mem_rd_o) begin
         chk("mrd_busy", 32'(m_busy), 32'd1);
         chk("mrd_while_valid", 32'(out_valid_o), 32'd0);
         chk("mrd_addr", mem_addr_o, 32'(m_memk * 4));
         chk("mrd_order", 32'(m_memk), 32'(m_mem_xfer));
         m_memk++;
      end
      if (done_o) n_done++;
      if (busy_o) busy_cycles++;
      if (ovr_seq != ovr_seen) begin
         m_cnt = ovr_val;
         ovr_seen = ovr_seq;
      end
      if (rst_i) begin
         m_cnt = 32'd0;
         m_busy = 1'b0;
         m_done = 1'b0;
         p_stall = 1'b0;
         exp_q.delete();
      end else begin
         ce = m_cnt;
         m_cnt = m_cnt + 32'd1;
         was_busy = m_busy;
         m_done = 1'b0;
         p_stall = out_valid_o && !out_ready_i;
         p_beat = cur;
         if (out_valid_o && out_ready_i && was_busy && exp_q.size() > 0) begin
            obs_q.push_back(cur);
            void'(exp_q.pop_front());
            n_beats++;
            if (cur.t == 2'd2) m_mem_xfer++;
            if (exp_q.size() == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end
         if (!was_busy && dump_req_i) begin
            exp_q.delete();
            obs_q.delete();
            exp_q.push_back({ce, 2'd0, 5'd0, 1'b0});
            for (int r = 0; r < 32; r++) exp_q.push_back({regs[r], 2'd1, 5'(r), 1'b0});
            for (int k = 0; k < 8; k++) exp_q.push_back({mword(k), 2'd2, 5'(k), k == 7});
            m_busy = 1'b1;
            n_beats = 0;
            m_memk = 0;
            m_mem_xfer = 0;
            busy_cycles = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
      out_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic run_to_done(input int budget, input string name);
      int d0;
      int c;
      d0 = n_done;
      c = 0;
      while (n_done == d0 && c < budget) begin
         step();
         c++;
      end
      chk({name, "_timeout"}, 32'(c < budget), 32'd1);
   endtask

   task automatic wait_beats(input int n, input string name);
      int c;
      c = 0;
      while (n_beats < n && c < 2000) begin
         step();
         c++;
      end
      chk({name, "_timeout"}, 32'(c < 2000), 32'd1);
   endtask

   task automatic request();
      dump_req_i = 1'b1;
      step();
      dump_req_i = 1'b0;
   endtask

   task automatic randomize_state();
      for (int r = 0; r < 32; r++) regs[r] = $urandom();
      for (int b = 0; b < 32; b++) mem_b[b] = 8'($urandom());
   endtask

   initial begin
      beat_t ref_q[$];
      int    nlast;
      int    c;
      randomize_state();
      regs[8] = 32'd10;
      regs[31] = 32'hDEADBEEF;
      mem_b[0] = 8'h05; mem_b[1] = 8'h00; mem_b[2] = 8'h00; mem_b[3] = 8'h00;

      repeat (3) step();
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_valid", 32'(out_valid_o), 32'd0);
      chk("rst_mem_rd", 32'(mem_rd_o), 32'd0);
      chk("rst_reg_addr", 32'(reg_addr_o), 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      chk("rst_data", out_data_o, 32'd0);
      chk("rst_meta", {24'd0, out_tag_o, out_idx_o, out_last_o}, 32'd0);
      rst_i = 1'b0;

      // basic dump, request while the counter reads 20
      c = 0;
      while (m_cnt != 32'd20 && c < 100) begin step(); c++; end
      request();
      run_to_done(500, "basic");
      chk("basic_beats", 32'(obs_q.size()), 32'd41);
      chk("basic_hdr", obs_q[0].d, 32'd20);
      chk("basic_r8", obs_q[9].d, 32'd10);
      chk("basic_r8_idx", 32'(obs_q[9].i), 32'd8);
      chk("basic_r31", obs_q[32].d, 32'hDEADBEEF);
      chk("basic_m0", obs_q[33].d, 32'd5);
      chk("basic_m0_tag", 32'(obs_q[33].t), 32'd2);
      chk("basic_busy_cycles", 32'(busy_cycles), 32'd49);
      nlast = 0;
      foreach (obs_q[i]) if (obs_q[i].l) nlast++;
      chk("basic_last_count", 32'(nlast), 32'd1);
      chk("basic_last_pos", 32'(obs_q[40].l), 32'd1);
      chk("basic_done_count", 32'(n_done), 32'd1);
      ref_q = obs_q;

      // backpressure: same payload after the header
      rnd_ready = 1'b1;
      repeat (3) step();
      request();
      run_to_done(3000, "bp");
      chk("bp_beats", 32'(obs_q.size()), 32'd41);
      for (int i = 1; i < 41; i++) chk("bp_same", obs_q[i].d, ref_q[i].d);

      // requests while busy are ignored; request held through done restarts
      rnd_ready = 1'b0;
      request();
      wait_beats(5, "wb5");
      request();
      wait_beats(30, "wb30");
      request();
      wait_beats(38, "wb38");
      c = n_done;
      dump_req_i = 1'b1;
      run_to_done(500, "busy_req");
      dump_req_i = 1'b0;
      chk("busy_req_one_done", 32'(n_done - c), 32'd1);
      chk("back_to_back_busy", 32'(busy_o), 32'd1);
      run_to_done(500, "b2b");
      chk("b2b_beats", 32'(obs_q.size()), 32'd41);

      // reset during memory word 3
      rnd_ready = 1'b1;
      repeat (2) step();
      request();
      c = 0;
      while (!(out_valid_o && out_tag_o == 2'd2 && out_idx_o == 5'd3) && c < 2000) begin step(); c++; end
      chk("mw3_timeout", 32'(c < 2000), 32'd1);
      c = n_done;
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_done", 32'(done_o), 32'd0);
      chk("mid_rst_cnt", dut.r_cnt, 32'd0);
      repeat (5) step();
      chk("mid_rst_no_done", 32'(n_done - c), 32'd0);
      request();
      run_to_done(3000, "after_rst");
      chk("after_rst_hdr", obs_q[0].d, 32'd5);
      chk("after_rst_beats", 32'(obs_q.size()), 32'd41);

      // random contents, random gaps, random backpressure
      for (int n = 0; n < 4; n++) begin
         randomize_state();
         repeat ($urandom_range(0, 9)) step();
         request();
         run_to_done(3000, "rand");
         chk("rand_beats", 32'(obs_q.size()), 32'd41);
      end

      // counter wrap
      rnd_ready = 1'b0;
      force dut.r_cnt = 32'hFFFF_FFFE;
      ovr_val = 32'hFFFF_FFFE;
      ovr_seq++;
      #1;
      release dut.r_cnt;
      step();
      request();
      chk("wrap_cnt", dut.r_cnt, 32'd0);
      run_to_done(500, "wrap");
      chk("wrap_hdr", obs_q[0].d, 32'hFFFF_FFFF);

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
